// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter that shares one 8x8 register file between requesters A and B.
// Each accepted transaction runs IDLE -> ACCESS -> DONE; every output is registered.
module regfile_port_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_a,
    input  logic                       we_a,
    input  logic [ADDR_W-1:0]          addr_a,
    input  logic [DATA_W-1:0]          wdata_a,
    output logic                       gnt_a,
    output logic                       done_a,
    input  logic                       req_b,
    input  logic                       we_b,
    input  logic [ADDR_W-1:0]          addr_b,
    input  logic [DATA_W-1:0]          wdata_b,
    output logic                       gnt_b,
    output logic                       done_b,
    output logic [DATA_W-1:0]          rdata,
    output logic [ADDR_W-1:0]          rf_read,
    output logic [(1<<ADDR_W)-1:0]     rf_load,
    output logic [DATA_W-1:0]          rf_din,
    input  logic [DATA_W-1:0]          rf_dout
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, stateNext;

    // rrPtrB=1 means B wins the next tie; ownerB marks the side being served.
    logic rrPtrB, rrPtrBNext;
    logic ownerB, ownerBNext;
    logic weLat,  weLatNext;

    logic                 pickB;
    logic                 selWe;
    logic [ADDR_W-1:0]    selAddr;
    logic [DATA_W-1:0]    selWdata;

    logic                 gntANext, gntBNext;
    logic                 doneANext, doneBNext;
    logic [DATA_W-1:0]    rdataNext;
    logic [ADDR_W-1:0]    rfReadNext;
    logic [NREGS-1:0]     rfLoadNext;
    logic [DATA_W-1:0]    rfDinNext;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, arbitration and next-output decode.
    always_comb begin
        stateNext  = state;
        rrPtrBNext = rrPtrB;
        ownerBNext = ownerB;
        weLatNext  = weLat;
        pickB      = 1'b0;
        selWe      = 1'b0;
        selAddr    = '0;
        selWdata   = '0;
        gntANext   = 1'b0;
        gntBNext   = 1'b0;
        doneANext  = 1'b0;
        doneBNext  = 1'b0;
        rdataNext  = rdata;
        rfReadNext = rf_read;
        rfLoadNext = '0;
        rfDinNext  = rf_din;

        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    pickB    = req_b && (!req_a || rrPtrB);
                    selWe    = pickB ? we_b    : we_a;
                    selAddr  = pickB ? addr_b  : addr_a;
                    selWdata = pickB ? wdata_b : wdata_a;

                    ownerBNext = pickB;
                    weLatNext  = selWe;
                    rfReadNext = selAddr;
                    rfDinNext  = selWdata;
                    gntANext   = !pickB;
                    gntBNext   = pickB;
                    if (selWe) begin
                        rfLoadNext[selAddr] = 1'b1;
                    end
                    stateNext = ACCESS;
                end
            end

            ACCESS: begin
                // rf_dout is valid here because rf_read was registered on entry.
                if (!weLat) begin
                    rdataNext = rf_dout;
                end
                doneANext = !ownerB;
                doneBNext = ownerB;
                stateNext = DONE;
            end

            DONE: begin
                rrPtrBNext = !ownerB;
                stateNext  = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Registered control and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtrB  <= 1'b0;
            ownerB  <= 1'b0;
            weLat   <= 1'b0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            rdata   <= '0;
            rf_read <= '0;
            rf_load <= '0;
            rf_din  <= '0;
        end else begin
            rrPtrB  <= rrPtrBNext;
            ownerB  <= ownerBNext;
            weLat   <= weLatNext;
            gnt_a   <= gntANext;
            gnt_b   <= gntBNext;
            done_a  <= doneANext;
            done_b  <= doneBNext;
            rdata   <= rdataNext;
            rf_read <= rfReadNext;
            rf_load <= rfLoadNext;
            rf_din  <= rfDinNext;
        end
    end

endmodule
